// File: rtl/qos_arb_mux_pkg.sv
// Shared encodings and defaults for the QoS arbitrating multiplexer.
package qos_arb_mux_pkg;

    localparam int unsigned N_CH_DEF     = 4;
    localparam int unsigned DATA_W_DEF   = 12;
    localparam int unsigned WEIGHT_W_DEF = 4;

    localparam logic MODE_PRIO = 1'b0;
    localparam logic MODE_WRR  = 1'b1;

    typedef enum logic {StIdle, StServe} arb_state_e;

endpackage

// File: rtl/qos_rr_pick.sv
// Rotating search: first requester at or after start, wrapping N_CH-1 to 0.
module qos_rr_pick
    import qos_arb_mux_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    localparam int unsigned IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int unsigned      sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        cand  = '0;
        // Walk from the far end so the closest requester is written last.
        for (int i = N_CH - 1; i >= 0; i--) begin
            sum = int'(start) + i;
            if (sum >= N_CH) begin
                sum = sum - N_CH;
            end
            cand = IDX_W'(sum);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/qos_arb_mux.sv
// Multiplexes N_CH show-ahead FIFOs onto one registered output stream using
// strict priority or weighted round-robin arbitration.
module qos_arb_mux
    import qos_arb_mux_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned WEIGHT_W = WEIGHT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            fifo_empty,
    input  logic [N_CH*DATA_W-1:0]     fifo_data,
    input  logic                       out_ready,
    input  logic                       mode,
    input  logic [N_CH*WEIGHT_W-1:0]   weights,
    output logic [N_CH-1:0]            pop,
    output logic [DATA_W-1:0]          data_out,
    output logic                       valid_out,
    output logic [$clog2(N_CH)-1:0]    grant_ch
);

    localparam int unsigned IDX_W = $clog2(N_CH);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, ptr_next;
    logic [WEIGHT_W-1:0] credit_q, credit_d, credit_load, w_pick;

    logic [IDX_W-1:0]  pick_start, pick_idx, sel_idx;
    logic              pick_found, sel_go, sel_any;

    assign ptr_next = (ptr_q == IDX_W'(N_CH - 1)) ? '0 : ptr_q + IDX_W'(1);

    // Strict priority is a rotating search anchored at channel 0.
    assign pick_start = (mode == MODE_PRIO) ? '0 :
                        (state_q == StIdle) ? ptr_q : ptr_next;

    qos_rr_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .req   (~fifo_empty),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign w_pick      = weights[pick_idx*WEIGHT_W +: WEIGHT_W];
    assign credit_load = (w_pick == '0) ? '0 : w_pick - WEIGHT_W'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        sel_go   = 1'b0;
        sel_idx  = pick_idx;
        if (mode == MODE_PRIO) begin
            // Keeps the WRR machine parked so a later switch starts from scratch.
            state_d  = StIdle;
            ptr_d    = '0;
            credit_d = '0;
            sel_go   = out_ready & pick_found;
        end else if (out_ready) begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        sel_go   = 1'b1;
                        state_d  = StServe;
                        ptr_d    = pick_idx;
                        credit_d = credit_load;
                    end
                end
                StServe: begin
                    if (!fifo_empty[ptr_q] && credit_q != '0) begin
                        sel_go   = 1'b1;
                        sel_idx  = ptr_q;
                        credit_d = credit_q - WEIGHT_W'(1);
                    end else if (pick_found) begin
                        sel_go   = 1'b1;
                        ptr_d    = pick_idx;
                        credit_d = credit_load;
                    end else begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    assign sel_any = sel_go & ~reset;
    assign pop     = sel_any ? (N_CH'(1) << sel_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            credit_q  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            grant_ch  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            credit_q  <= credit_d;
            valid_out <= sel_any;
            if (sel_any) begin
                data_out <= fifo_data[sel_idx*DATA_W +: DATA_W];
                grant_ch <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_qos_arb_mux.sv
// Directed bench for qos_arb_mux: priority, WRR bursts, stalls, reset, mode switch.
module tb_qos_arb_mux;

    logic        clk;
    logic        reset;
    logic [3:0]  fifo_empty;
    logic [47:0] fifo_data;
    logic        out_ready;
    logic        mode;
    logic [15:0] weights;
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic        valid_out;
    logic [1:0]  grant_ch;

    int total = 0;
    int bad   = 0;
    int last  = 0;
    logic [11:0] head [4];

    qos_arb_mux dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .out_ready  (out_ready),
        .mode       (mode),
        .weights    (weights),
        .pop        (pop),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .grant_ch   (grant_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ch >= 0: expect that channel popped this cycle; ch < 0: expect no pop.
    task automatic step(input string tag, input int ch);
        logic [3:0] exp_pop;
        exp_pop = 4'b0000;
        if (ch >= 0) exp_pop[ch] = 1'b1;
        #1;
        chk({tag, ".pop"}, 32'(pop), 32'(exp_pop));
        @(posedge clk);
        #1;
        if (ch >= 0) begin
            last = ch;
            chk({tag, ".valid"}, 32'(valid_out), 32'd1);
        end else begin
            chk({tag, ".valid"}, 32'(valid_out), 32'd0);
        end
        chk({tag, ".grant"}, 32'(grant_ch), 32'(last));
        chk({tag, ".data"}, 32'(data_out), 32'(head[last]));
    endtask

    initial begin
        head[0] = 12'h1A0;
        head[1] = 12'h2B1;
        head[2] = 12'h3C2;
        head[3] = 12'h4D3;
        fifo_data  = {head[3], head[2], head[1], head[0]};
        reset      = 1'b1;
        mode       = 1'b0;
        fifo_empty = 4'hF;
        out_ready  = 1'b1;
        weights    = 16'h1123;

        #1;
        chk("rst.valid", 32'(valid_out), 32'd0);
        chk("rst.data", 32'(data_out), 32'd0);
        chk("rst.grant", 32'(grant_ch), 32'd0);
        fifo_empty = 4'h0;
        #1;
        chk("rst.pop", 32'(pop), 32'd0);
        #1;
        reset = 1'b0;

        // Strict priority
        step("prio0", 0);
        step("prio1", 0);
        step("prio2", 0);
        fifo_empty = 4'b0011;
        step("prio_lo_empty", 2);
        fifo_empty = 4'b1111;
        step("prio_all_empty", -1);
        fifo_empty = 4'b0000;
        out_ready  = 1'b0;
        step("prio_not_ready", -1);
        out_ready = 1'b1;

        // WRR weights ch3..ch0 = 1,1,2,3
        mode = 1'b1;
        step("wrr_a0", 0);
        step("wrr_a1", 0);
        step("wrr_a2", 0);
        step("wrr_a3", 1);
        step("wrr_a4", 1);
        step("wrr_a5", 2);
        step("wrr_a6", 3);
        step("wrr_a7", 0);
        step("wrr_a8", 0);
        step("wrr_a9", 0);
        step("wrr_a10", 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("stall", -1);
        out_ready = 1'b1;
        step("resume_ch1", 1);
        step("resume_ch2", 2);
        // ch3 weight changes to 2; sampled at its next load
        weights = 16'h2123;
        step("w_load_ch3", 3);
        mode = 1'b0;
        step("mode_switch", 0);

        // Single requester ch2 with weight 2
        mode       = 1'b1;
        weights    = 16'h1223;
        fifo_empty = 4'b1011;
        for (int i = 0; i < 4; i++) step("solo_ch2", 2);

        // Weight 0 on ch0 behaves as 1
        mode = 1'b0;
        step("prio_solo", 2);
        mode       = 1'b1;
        weights    = 16'h1120;
        fifo_empty = 4'b0000;
        step("w0_a0", 0);
        step("w0_a1", 1);
        step("w0_a2", 1);
        step("w0_a3", 2);
        step("w0_a4", 3);
        step("w0_a5", 0);
        step("w0_a6", 1);
        step("w0_a7", 1);
        // All empty in SERVE: back to IDLE, ptr stays at 1
        fifo_empty = 4'b1111;
        step("serve_empty", -1);
        fifo_empty = 4'b1100;
        step("idle_ptr_kept", 1);

        // Reset mid-SERVE
        fifo_empty = 4'b0000;
        step("pre_rst_a", 1);
        step("pre_rst_b", 2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst.valid", 32'(valid_out), 32'd0);
        chk("mid_rst.data", 32'(data_out), 32'd0);
        chk("mid_rst.grant", 32'(grant_ch), 32'd0);
        chk("mid_rst.pop", 32'(pop), 32'd0);
        #1;
        reset = 1'b0;
        step("post_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qos_arb_mux.md
QOS_ARB_MUX -- requirements
Module: qos_arb_mux

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of FIFO channels, 2..16.
REQ-002 SHALL have parameter DATA_W, default 12: word width per channel.
REQ-003 SHALL have parameter WEIGHT_W, default 4: width of each per-channel WRR weight.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port fifo_empty, input, N_CH: bit i high when channel i FIFO is empty.
REQ-007 SHALL have port fifo_data, input, N_CH*DATA_W: show-ahead head word; channel i occupies [i*DATA_W +: DATA_W].
REQ-008 SHALL have port out_ready, input, 1: downstream can accept a word this cycle.
REQ-009 SHALL have port mode, input, 1: 0 = strict priority, 1 = weighted round-robin (WRR).
REQ-010 SHALL have port weights, input, N_CH*WEIGHT_W: per-channel WRR burst size; weight 0 is treated as 1.
REQ-011 SHALL have port pop, output, N_CH: one-hot or zero, combinational, read strobe to the FIFOs.
REQ-012 SHALL have port data_out, output, DATA_W: registered word of the granted channel.
REQ-013 SHALL have port valid_out, output, 1: registered; data_out is valid.
REQ-014 SHALL have port grant_ch, output, $clog2(N_CH): registered index of the channel that supplied data_out.

Function
REQ-015 pop SHALL be all zeros whenever out_ready=0 or fifo_empty is all ones.
REQ-016 In mode 0, pop SHALL select the lowest-index non-empty channel.
REQ-017 In mode 1, the FSM SHALL have states IDLE and SERVE, a pointer ptr, and a credit counter.
REQ-018 In IDLE with any request and out_ready=1, the FSM SHALL grant the first non-empty channel at or after ptr (rotating, wrap N_CH-1 to 0), load credit = weight-1, and go to SERVE.
REQ-019 In SERVE, ptr's channel SHALL be popped while it is non-empty and credit>0; each pop decrements credit.
REQ-020 In SERVE, when credit=0 or ptr's channel is empty, the grant SHALL move to the next non-empty channel after ptr, with credit reloaded from its weight.
REQ-021 If that next channel is ptr itself (only requester), the FSM SHALL re-grant ptr with credit reloaded, with no bubble.
REQ-022 In SERVE with all channels empty, the FSM SHALL go to IDLE with ptr unchanged.
REQ-023 While out_ready=0, FSM state, ptr and credit SHALL hold.
REQ-024 A mode change SHALL force IDLE, ptr=0 and credit=0 on the next edge; pop SHALL follow the new mode from that edge.
REQ-025 When pop[i]=1 at edge t, data_out SHALL equal fifo_data channel i, valid_out SHALL be 1 and grant_ch SHALL be i after edge t (latency 1).
REQ-026 With no pop at edge t, valid_out SHALL be 0 after edge t and data_out/grant_ch SHALL hold their values.
REQ-027 weights SHALL be sampled only at the credit load point.
REQ-028 Credit arithmetic SHALL be WEIGHT_W-bit unsigned and SHALL never underflow.

Reset
REQ-029 reset SHALL force data_out=0, valid_out=0, grant_ch=0, state=IDLE, ptr=0, credit=0 immediately, independent of clk.
REQ-030 pop SHALL be 0 while reset=1.
REQ-031 The first pop SHALL occur no earlier than the first rising edge after reset is released.

Structure
REQ-032 A shared package SHALL hold the mode encodings (MODE_PRIO=0, MODE_WRR=1), the FSM state enum, and the defaults for N_CH, DATA_W and WEIGHT_W.
REQ-033 The rotating-priority search SHALL be a sub-module qos_rr_pick (inputs: request vector, start index; outputs: found, index).
REQ-034 All outputs except pop SHALL be driven directly from flops.

Verification
REQ-035 Mode 0, fifo_empty=4'b0000, out_ready=1 for 3 cycles -> pop=0001 each cycle; grant_ch=0, valid_out=1 from the next cycle onward.
REQ-036 Mode 1, weights={1,1,2,3} (ch3..ch0), all channels non-empty -> grant sequence 0,0,0,1,1,2,3,0,0,0, ...
REQ-037 Mode 1, only ch2 non-empty with weight 2 -> pop=0100 every cycle with no bubble; credit reloads.
REQ-038 out_ready dropped mid-burst of ch1 (credit 1 left) for 4 cycles -> pop=0 and valid_out=0; resuming gives exactly one more ch1 pop, then ch2.
REQ-039 reset asserted mid-SERVE between edges -> valid_out=0 and data_out=0 immediately; after release, first WRR grant is ch0.
REQ-040 Mode toggled 1->0 while serving ch3 with ch0 non-empty -> the next pop is 0001.
